// File: rtl/fattree_endpoint_injector_pkg.sv
// Shared definitions for the fat-tree endpoint injector: flit field positions,
// FSM state encoding and the flit assembly helper.
package fattree_inj_pkg;

  // The helper works on a generously sized vector; callers truncate to their Fw.
  localparam int MAX_V    = 16;
  localparam int MAX_FPAY = 256;
  localparam int MAX_FW   = 2 + MAX_V + MAX_FPAY;

  typedef enum logic {ST_IDLE = 1'b0, ST_SEND = 1'b1} inj_state_e;

  function automatic int head_bit(input int v, input int fpay); return fpay + v + 1; endfunction
  function automatic int tail_bit(input int v, input int fpay); return fpay + v;     endfunction
  function automatic int vc_ofs(input int fpay);                return fpay;         endfunction

  // Head payload, low to high: dest, src, timestamp.
  function automatic int dest_ofs();             return 0;       endfunction
  function automatic int src_ofs(input int eaw); return eaw;     endfunction
  function automatic int ts_ofs(input int eaw);  return 2 * eaw; endfunction

  // vc_oh and payload must already be zero-extended from their true widths.
  function automatic logic [MAX_FW-1:0] make_flit(input int v, input int fpay,
                                                  input logic head, input logic tail,
                                                  input logic [MAX_V-1:0] vc_oh,
                                                  input logic [MAX_FPAY-1:0] payload);
    return (MAX_FW'(head)  << head_bit(v, fpay)) |
           (MAX_FW'(tail)  << tail_bit(v, fpay)) |
           (MAX_FW'(vc_oh) << vc_ofs(fpay))      |
            MAX_FW'(payload);
  endfunction

endpackage

// File: rtl/fattree_endpoint_injector_if.sv
// Packet-descriptor handshake between a local traffic source and the injector.
interface fattree_endpoint_injector_if #(
  parameter int EAw  = 4,
  parameter int Lenw = 8,
  parameter int VCw  = 1
);
  logic            pkt_valid;
  logic            pkt_ready;
  logic [EAw-1:0]  pkt_dest;
  logic [Lenw-1:0] pkt_len;
  logic [VCw-1:0]  pkt_vc;

  modport master (output pkt_valid, pkt_dest, pkt_len, pkt_vc, input pkt_ready);
  modport slave  (input pkt_valid, pkt_dest, pkt_len, pkt_vc, output pkt_ready);
endinterface

// File: rtl/endp_credit_counter.sv
// Per-VC credit counter for one router input buffer; starts full at B.
module endp_credit_counter #(
  parameter int B = 4,
  localparam int CW = $clog2(B + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          dec,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          nonzero,
  output logic          ovf
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= CW'(B);
      ovf   <= 1'b0;
    end else begin
      // Simultaneous send and return cancel out.
      unique case ({inc, dec})
        2'b10: begin
          if (count == CW'(B)) ovf <= 1'b1;
          else                 count <= count + CW'(1);
        end
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  assign nonzero = (count != '0);

endmodule

// File: rtl/fattree_endpoint_injector.sv
// Per-endpoint packet injector: segments descriptors into head/body/tail flits
// under per-VC credit flow control. Optional macro INJECT_TIMESTAMP_EN stamps heads.
module fattree_endpoint_injector
  import fattree_inj_pkg::*;
#(
  parameter int V    = 2,
  parameter int B    = 4,
  parameter int Fpay = 32,
  parameter int EAw  = 4,
  parameter int Lenw = 8,
  parameter int TSw  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_i,
  input  logic [EAw-1:0]       src_addr,
  fattree_endpoint_injector_if.slave desc,
  output logic [2+V+Fpay-1:0]  flit_out,
  output logic                 flit_out_wr,
  input  logic [V-1:0]         credit_in,
  output logic [15:0]          sent_pkt_cnt,
  output logic                 busy,
  output logic                 err_credit_ovf
);

  localparam int VCw      = (V > 1) ? $clog2(V) : 1;
  localparam int Fw       = 2 + V + Fpay;
  localparam int CW       = $clog2(B + 1);
  localparam int DEST_OFS = dest_ofs();
  localparam int SRC_OFS  = src_ofs(EAw);
  localparam int TS_OFS   = ts_ofs(EAw);

  if (Fpay < 2 * EAw + TSw) begin : g_bad_fpay
    $error("Fpay too narrow for the head payload");
  end
  if (V > MAX_V || Fpay > MAX_FPAY) begin : g_bad_size
    $error("V or Fpay exceeds flit helper limits");
  end

  inj_state_e          state_q, state_d;
  logic                started_q;
  logic [VCw-1:0]      vc_q;
  logic [EAw-1:0]      dest_q;
  logic [Lenw-1:0]     len_q, idx_q;
  logic [TSw-1:0]      ts_q;
  logic [V-1:0]        cr_dec, cr_nz, cr_ovf;
  logic [V-1:0][CW-1:0] cr_cnt;
  logic                accept, send, is_tail;
  logic [V-1:0]        vc_oh;
  logic [Fpay-1:0]     head_pay, pay;
  logic                unused_cnt;

  assign accept  = (state_q == ST_IDLE) && started_q && desc.pkt_valid;
  assign send    = (state_q == ST_SEND) && cr_nz[vc_q];
  assign is_tail = (idx_q == len_q - Lenw'(1));

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept)            state_d = ST_SEND;
      ST_SEND: if (send && is_tail)   state_d = ST_IDLE;
      default:                        state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    head_pay                   = '0;
    head_pay[DEST_OFS +: EAw]  = dest_q;
    head_pay[SRC_OFS  +: EAw]  = src_addr;
    head_pay[TS_OFS   +: TSw]  = ts_q;
    vc_oh                      = V'(1) << vc_q;
    pay                        = (idx_q == '0) ? head_pay : Fpay'(idx_q);
  end

  // Outputs depend only on registered state and credit counts.
  always_comb begin
    desc.pkt_ready = (state_q == ST_IDLE) && started_q;
    busy           = (state_q == ST_SEND);
    flit_out_wr    = send;
    err_credit_ovf = |cr_ovf;
    flit_out       = '0;
    if (send)
      flit_out = Fw'(make_flit(V, Fpay, idx_q == '0, is_tail, MAX_V'(vc_oh), MAX_FPAY'(pay)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      started_q    <= 1'b0;
      vc_q         <= '0;
      dest_q       <= '0;
      len_q        <= '0;
      idx_q        <= '0;
      sent_pkt_cnt <= '0;
    end else begin
      if (start_i) started_q <= 1'b1;
      if (accept) begin
        vc_q   <= desc.pkt_vc;
        dest_q <= desc.pkt_dest;
        len_q  <= (desc.pkt_len == '0) ? Lenw'(1) : desc.pkt_len;
        idx_q  <= '0;
      end
      if (send) begin
        idx_q <= idx_q + Lenw'(1);
        if (is_tail) sent_pkt_cnt <= sent_pkt_cnt + 16'd1;
      end
    end
  end

`ifdef INJECT_TIMESTAMP_EN
  always_ff @(posedge clk) begin
    if (reset) ts_q <= '0;
    else       ts_q <= ts_q + TSw'(1);
  end
`else
  assign ts_q = '0;
`endif

  for (genvar i = 0; i < V; i++) begin : g_cr
    assign cr_dec[i] = send && (vc_q == VCw'(i));
    endp_credit_counter #(.B(B)) u_cr (
      .clk     (clk),
      .reset   (reset),
      .dec     (cr_dec[i]),
      .inc     (credit_in[i]),
      .count   (cr_cnt[i]),
      .nonzero (cr_nz[i]),
      .ovf     (cr_ovf[i])
    );
  end

  // Raw counts are kept visible for debug only.
  assign unused_cnt = ^cr_cnt;

endmodule

// File: tb/tb_fattree_endpoint_injector.sv
// Scoreboard bench for fattree_endpoint_injector (V=2, B=4, Fpay=32, EAw=4).
module tb_fattree_endpoint_injector;

  localparam logic [3:0] SRC = 4'd2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_i = 1'b0;
  logic [35:0] flit_out;
  logic        flit_out_wr;
  logic [1:0]  credit_in = 2'b00;
  logic [15:0] sent_pkt_cnt;
  logic        busy, err_credit_ovf;

  int n_chk = 0, n_pass = 0;

  typedef struct {
    bit       head, tail;
    bit       vc;
    bit [3:0] dest;
    bit [7:0] idx;
  } exp_t;
  exp_t q[$];

  fattree_endpoint_injector_if #(.EAw(4), .Lenw(8), .VCw(1)) desc();

  fattree_endpoint_injector dut (
    .clk            (clk),
    .reset          (reset),
    .start_i        (start_i),
    .src_addr       (SRC),
    .desc           (desc),
    .flit_out       (flit_out),
    .flit_out_wr    (flit_out_wr),
    .credit_in      (credit_in),
    .sent_pkt_cnt   (sent_pkt_cnt),
    .busy           (busy),
    .err_credit_ovf (err_credit_ovf)
  );

  always #5 clk = ~clk;

  logic [15:0] tb_ts;
  always @(posedge clk) tb_ts <= reset ? 16'd0 : tb_ts + 16'd1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [35:0] mk(input exp_t e, input logic [15:0] ts);
    logic [1:0]  oh;
    logic [31:0] pay;
    oh  = 2'b01 << e.vc;
    pay = e.head ? {8'h00, ts, SRC, e.dest} : 32'(e.idx);
    return {e.head, e.tail, oh, pay};
  endfunction

  // Scoreboard monitor: every written flit must match the next expected one.
  always @(negedge clk) begin
    if (!reset) begin
      if (flit_out_wr) begin
        if (q.size() == 0) chk("unexp_flit", flit_out, 36'h0);
        else begin
          exp_t e;
          logic [15:0] ts;
          e = q.pop_front();
`ifdef INJECT_TIMESTAMP_EN
          ts = tb_ts;
`else
          ts = 16'd0;
`endif
          chk("flit", flit_out, mk(e, ts));
        end
      end else chk("idle_zero", flit_out, 36'h0);
    end
  end

  task automatic issue(input logic [3:0] dest, input logic [7:0] len, input logic vc);
    int l;
    bit ok = 0;
    @(posedge clk); #1;
    desc.pkt_valid = 1'b1; desc.pkt_dest = dest; desc.pkt_len = len; desc.pkt_vc = vc;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (desc.pkt_ready) begin ok = 1; break; end
    end
    if (!ok) chk("accept_timeout", 0, 1);
    l = (len == 0) ? 1 : int'(len);
    for (int i = 0; i < l; i++) q.push_back('{i == 0, i == l - 1, vc, dest, 8'(i)});
    @(posedge clk); #1;
    desc.pkt_valid = 1'b0;
  endtask

  task automatic wait_tail(input string tag);
    bit ok = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (flit_out_wr && flit_out[34]) begin ok = 1; break; end
    end
    if (!ok) chk({tag, "_tail_timeout"}, 0, 1);
    @(negedge clk);
    chk({tag, "_rdy_after"}, desc.pkt_ready, 1);
    chk({tag, "_busy_after"}, busy, 0);
  endtask

  task automatic credit_pulse(input logic [1:0] m);
    @(posedge clk); #1 credit_in = m;
    @(posedge clk); #1 credit_in = 2'b00;
  endtask

  initial begin
    int bad_rdy, bad_wr, nfl;
    desc.pkt_valid = 1'b0; desc.pkt_dest = '0; desc.pkt_len = '0; desc.pkt_vc = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", desc.pkt_ready, 0);
    chk("rst_wr", flit_out_wr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", sent_pkt_cnt, 0);
    chk("rst_ovf", err_credit_ovf, 0);
    chk("rst_cr0", dut.cr_cnt[0], 4);
    chk("rst_cr1", dut.cr_cnt[1], 4);

    // No start: descriptors must be ignored.
    desc.pkt_valid = 1'b1; desc.pkt_len = 8'd2;
    bad_rdy = 0; bad_wr = 0;
    repeat (20) begin
      @(negedge clk);
      if (desc.pkt_ready) bad_rdy++;
      if (flit_out_wr) bad_wr++;
    end
    chk("nostart_ready", bad_rdy, 0);
    chk("nostart_wr", bad_wr, 0);
    desc.pkt_valid = 1'b0;
    @(posedge clk); #1 start_i = 1'b1;
    @(negedge clk); chk("start_same_cycle", desc.pkt_ready, 0);
    @(posedge clk); #1 start_i = 1'b0;
    @(negedge clk); chk("start_next_cycle", desc.pkt_ready, 1);

    // 3-flit packet on VC1.
    issue(4'd5, 8'd3, 1'b1);
    @(negedge clk); chk("p1_head_lat", flit_out_wr, 1);
    chk("p1_busy", busy, 1);
    wait_tail("p1");
    chk("p1_sent", sent_pkt_cnt, 1);

    // 6 flits with 4 credits on VC0: stall, then one flit per returned credit.
    issue(4'd3, 8'd6, 1'b0);
    nfl = 0;
    repeat (8) begin @(negedge clk); if (flit_out_wr) nfl++; end
    chk("p2_flits_before_stall", nfl, 4);
    @(posedge clk); #1 credit_in = 2'b01;
    @(negedge clk); chk("p2_cr_cycle", flit_out_wr, 0);
    @(posedge clk); #1 credit_in = 2'b00;
    @(negedge clk); chk("p2_cr_next", flit_out_wr, 1);
    chk("p2_not_tail", flit_out[34], 0);
    @(negedge clk); chk("p2_stall_again", flit_out_wr, 0);
    credit_pulse(2'b01);
    @(negedge clk); chk("p2_tail_wr", flit_out_wr, 1);
    chk("p2_tail_bit", flit_out[34], 1);
    @(negedge clk); chk("p2_sent", sent_pkt_cnt, 2);

    // Send and credit return on the same VC in the same cycle.
    credit_pulse(2'b01);
    @(negedge clk); chk("p3_cr_one", dut.cr_cnt[0], 1);
    issue(4'd9, 8'd3, 1'b0);
    credit_in = 2'b01;
    @(negedge clk); chk("p3_head", flit_out_wr, 1);
    @(posedge clk); #1 credit_in = 2'b00;
    @(negedge clk); chk("p3_cnt_held", dut.cr_cnt[0], 1);
    chk("p3_next_send", flit_out_wr, 1);
    @(negedge clk); chk("p3_stall", flit_out_wr, 0);
    credit_pulse(2'b01);
    @(negedge clk); chk("p3_tail", flit_out[35:34], 2'b01);
    @(negedge clk); chk("p3_sent", sent_pkt_cnt, 3);

    // Overflow: refill to B, then one more credit.
    repeat (4) credit_pulse(2'b01);
    @(negedge clk); chk("ovf_full", dut.cr_cnt[0], 4);
    chk("ovf_clear", err_credit_ovf, 0);
    credit_pulse(2'b01);
    @(negedge clk); chk("ovf_set", err_credit_ovf, 1);
    chk("ovf_cnt_held", dut.cr_cnt[0], 4);

    // len=0 gives a single head+tail flit.
    issue(4'd7, 8'd0, 1'b0);
    @(negedge clk); chk("p4_wr", flit_out_wr, 1);
    chk("p4_head_tail", flit_out[35:34], 2'b11);
    @(negedge clk); chk("p4_sent", sent_pkt_cnt, 4);
    chk("p4_ready", desc.pkt_ready, 1);

    // Reset after 2 of 5 flits aborts the packet.
    issue(4'd6, 8'd5, 1'b0);
    @(negedge clk);
    @(negedge clk); #1 reset = 1'b1;
    q.delete();
    @(negedge clk);
    chk("rst2_wr", flit_out_wr, 0);
    chk("rst2_flit", flit_out, 0);
    chk("rst2_busy", busy, 0);
    chk("rst2_ready", desc.pkt_ready, 0);
    chk("rst2_cnt", sent_pkt_cnt, 0);
    chk("rst2_ovf", err_credit_ovf, 0);
    chk("rst2_cr0", dut.cr_cnt[0], 4);
    chk("rst2_cr1", dut.cr_cnt[1], 4);
    @(posedge clk); #1 reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst2_not_started", desc.pkt_ready, 0);
    @(posedge clk); #1 start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    issue(4'd1, 8'd2, 1'b1);
    @(negedge clk); chk("p5_head_bit", flit_out[35:34], 2'b10);
    wait_tail("p5");
    chk("p5_sent", sent_pkt_cnt, 1);
    chk("sb_empty", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout n_pass=%0d n_chk=%0d", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

endmodule
